// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache with tree
// pseudo-LRU replacement, whole-cache flush and hit/miss counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   proc_read/proc_addr      fetch request and word address
//   proc_stall/proc_rdata    hold request / instruction word (0-cycle on hit)
//   flush                    invalidate all lines (deferred while filling)
//   mem_read/mem_addr        block fill request and block address
//   mem_write/mem_wdata      unused write channel, tied to 0
//   mem_rdata/mem_ready      128-bit fill data and its valid strobe
//   hit_cnt/miss_cnt         wrapping 32-bit event counters
module icache_nway #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 8,
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_read,
  input  logic [ADDR_W-1:0] proc_addr,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  input  logic              flush,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int unsigned LVL    = $clog2(WAYS);
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  // Heap-indexed tree bits: bit n is node n, bit 0 is never used
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS : 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  latched_addr;
  logic               flush_pending;
  logic [WAYS-1:0]    valid [SETS];
  logic [TAG_W-1:0]   tags  [SETS][WAYS];
  logic [127:0]       data  [SETS][WAYS];
  logic [PLRU_W-1:0]  plru  [SETS];

  logic [ADDR_W-1:0]  look_addr;
  logic [IDX_W-1:0]   look_set;
  logic [TAG_W-1:0]   look_tag;
  logic [6:0]         word_lsb;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [127:0]       hit_line;
  logic [WAY_W-1:0]   victim;
  logic               found_inv;
  logic [PLRU_W-1:0]  plru_cur;
  logic [PLRU_W-1:0]  plru_next;
  logic [PLRU_W-1:0]  plru_sh;
  logic [WAY_W-1:0]   upd_way;
  logic [WAY_W-1:0]   way_sh;
  int                 node_v;
  int                 node_u;

  // Lookup runs on the live address when idle, on the miss address while filling
  assign look_addr = (state == FETCH) ? latched_addr : proc_addr;
  assign look_set  = look_addr[IDX_W+1:2];
  assign look_tag  = look_addr[ADDR_W-1:IDX_W+2];
  assign word_lsb  = {look_addr[1:0], 5'd0};
  assign plru_cur  = plru[look_set];

  // Tag compare across all ways
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid[look_set][w] && tags[look_set][w] == look_tag) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_line = data[look_set][w];
      end
    end
  end

  assign proc_rdata = hit_line[word_lsb +: 32];
  assign proc_stall = proc_read && !(state == IDLE && hit && !flush && !flush_pending);
  assign mem_addr   = look_addr[ADDR_W-1:2];
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  // Victim: lowest invalid way, else walk the tree from the root
  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    node_v    = 1;
    plru_sh   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!found_inv && !valid[look_set][w]) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int l = 0; l < int'(LVL); l++) begin
        plru_sh = plru_cur >> node_v;
        node_v  = 2 * node_v + int'(plru_sh[0]);
      end
      victim = WAY_W'(node_v - int'(WAYS));
    end
  end

  // Point every node on the accessed way's path away from it
  assign upd_way = (state == FETCH) ? victim : hit_way;

  always_comb begin
    plru_next = plru_cur;
    node_u    = 1;
    way_sh    = '0;
    for (int l = 0; l < int'(LVL); l++) begin
      way_sh    = upd_way >> (int'(LVL) - 1 - l);
      plru_next = (plru_next & ~(PLRU_W'(1) << node_u)) |
                  (PLRU_W'(!way_sh[0]) << node_u);
      node_u    = 2 * node_u + int'(way_sh[0]);
    end
  end

  // Control FSM, cache arrays and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      latched_addr  <= '0;
      flush_pending <= 1'b0;
      mem_read      <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            flush_pending <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
              valid[s] <= '0;
              plru[s]  <= '0;
            end
          end else if (proc_read) begin
            if (hit) begin
              plru[look_set] <= plru_next;
              hit_cnt        <= hit_cnt + 32'd1;
            end else begin
              latched_addr <= proc_addr;
              miss_cnt     <= miss_cnt + 32'd1;
              mem_read     <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          // A flush mid-fill is remembered and applied in the next idle cycle
          if (flush) flush_pending <= 1'b1;
          if (mem_ready) begin
            mem_read <= 1'b0;
            for (int w = 0; w < int'(WAYS); w++) begin
              if (victim == WAY_W'(w)) begin
                data[look_set][w]  <= mem_rdata;
                tags[look_set][w]  <= look_tag;
                valid[look_set][w] <= 1'b1;
              end
            end
            plru[look_set] <= plru_next;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: checks icache_nway (4-way/8-set and a direct-mapped build)
// against a table of directed reads, hand sequences for flush/reset corners,
// and random reads compared with a set/way/tree reference model.
module tb_icache_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, proc_read, flush, mem_ready;
  logic [29:0]  proc_addr;
  logic         proc_stall, mem_read, mem_write;
  logic [31:0]  proc_rdata, hit_cnt, miss_cnt;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  logic         p1_read, p1_stall, m1_read, m1_write, m1_ready;
  logic [29:0]  p1_addr;
  logic [31:0]  p1_rdata, h1_cnt, x1_cnt;
  logic [27:0]  m1_addr;
  logic [127:0] m1_wdata, m1_rdata;

  int checks = 0;
  int errors = 0;

  icache_nway #(.WAYS(4), .SETS(8), .ADDR_W(30)) dut (
    .clk(clk), .rst(rst), .proc_read(proc_read), .proc_addr(proc_addr),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  icache_nway #(.WAYS(1), .SETS(8), .ADDR_W(30)) dut1 (
    .clk(clk), .rst(rst), .proc_read(p1_read), .proc_addr(p1_addr),
    .proc_stall(p1_stall), .proc_rdata(p1_rdata), .flush(1'b0),
    .mem_read(m1_read), .mem_write(m1_write), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .mem_ready(m1_ready),
    .hit_cnt(h1_cnt), .miss_cnt(x1_cnt)
  );

  // Backing memory: every word holds a tag derived from its own word address
  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = word_of({b, 2'(i)});
    return r;
  endfunction

  always_comb mem_rdata = mem_block(mem_addr);
  always_comb m1_rdata  = mem_block(m1_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: 8 sets x 4 ways, tree node bits kept per set (nodes 1..3)
  bit          m_valid [8][4];
  logic [24:0] m_tag   [8][4];
  bit          m_plru  [8][4];
  int          m_hits, m_misses;

  function automatic void model_flush();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_plru[s][w]  = 1'b0;
      end
  endfunction

  // Walk from leaf to root; a left child makes its parent point right (1)
  function automatic void touch(input int s, input int w);
    int node = w + 4;
    while (node > 1) begin
      m_plru[s][node / 2] = (node % 2 == 0);
      node = node / 2;
    end
  endfunction

  // Returns 1 on hit; on miss installs the block as the hardware would
  function automatic bit model_access(input logic [29:0] a);
    int s = int'(a[4:2]);
    int hw = -1;
    int v = -1;
    int node = 1;
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[29:5]) hw = w;
    if (hw >= 0) begin
      touch(s, hw);
      m_hits++;
      return 1'b1;
    end
    for (int w = 0; w < 4; w++)
      if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) begin
      while (node < 4) node = 2 * node + int'(m_plru[s][node]);
      v = node - 4;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[29:5];
    touch(s, v);
    m_misses++;
    return 1'b0;
  endfunction

  // One fetch on the 4-way cache; called and returning just after a falling edge
  task automatic read_op(input logic [29:0] a, input int k, input string nm, output bit was_hit);
    int stalls = 0;
    int fc = 0;
    bit done = 1'b0;
    bit exp_hit;
    exp_hit   = model_access(a);
    proc_read = 1'b1;
    proc_addr = a;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!proc_stall) done = 1'b1;
      else begin
        if (stalls == 0) begin
          chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(a[29:2]));
          chk({nm, "_miss_cycle_mem_read"}, 32'(mem_read), 32'd0);
        end
        stalls++;
        if (mem_read) begin
          if (fc == k) mem_ready = 1'b1;
          fc++;
        end
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    chk({nm, "_completes"}, 32'(done), 32'd1);
    chk({nm, "_stalls"}, 32'(stalls), exp_hit ? 32'd0 : 32'(k + 2));
    chk({nm, "_rdata"}, proc_rdata, word_of(a));
    if (!exp_hit) m_hits++;  // replayed lookup after the fill counts as a hit
    was_hit = (stalls == 0);
    @(posedge clk);
    @(negedge clk);
    proc_read = 1'b0;
  endtask

  // One fetch on the direct-mapped cache, fill data returned immediately
  task automatic read1(input logic [29:0] a, input bit exp_hit);
    int stalls = 0;
    bit done = 1'b0;
    p1_read = 1'b1;
    p1_addr = a;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!p1_stall) done = 1'b1;
      else begin
        stalls++;
        if (m1_read) m1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m1_ready = 1'b0;
      end
    end
    chk("w1_completes", 32'(done), 32'd1);
    chk("w1_stalls", 32'(stalls), exp_hit ? 32'd0 : 32'd2);
    chk("w1_rdata", p1_rdata, word_of(a));
    @(posedge clk);
    @(negedge clk);
    p1_read = 1'b0;
  endtask

  typedef struct {
    logic [29:0] addr;
    int          k;
    bit          exp_hit;
  } vec_t;

  vec_t tbl [11];
  bit   h;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, limit 300000 expected less");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{30'h005, 3, 1'b0};  // cold miss, late memory
    tbl[1]  = '{30'h000, 1, 1'b0};
    tbl[2]  = '{30'h020, 0, 1'b0};
    tbl[3]  = '{30'h040, 2, 1'b0};
    tbl[4]  = '{30'h060, 0, 1'b0};  // set 0 now full
    tbl[5]  = '{30'h000, 0, 1'b1};
    tbl[6]  = '{30'h080, 1, 1'b0};  // evicts way 2 (0x040)
    tbl[7]  = '{30'h040, 0, 1'b0};
    tbl[8]  = '{30'h000, 0, 1'b1};
    tbl[9]  = '{30'h020, 0, 1'b0};  // evicted by the 0x040 refill
    tbl[10] = '{30'h007, 0, 1'b1};  // same block as 0x005, last word

    rst = 1'b1; proc_read = 1'b0; proc_addr = '0; flush = 1'b0; mem_ready = 1'b0;
    p1_read = 1'b0; p1_addr = '0; m1_ready = 1'b0;
    m_hits = 0; m_misses = 0;
    model_flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall", 32'(proc_stall), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    chk("reset_miss_cnt", miss_cnt, 32'd0);
    chk("mem_write_tied", 32'(mem_write), 32'd0);
    chk("mem_wdata_tied", 32'(|mem_wdata), 32'd0);

    // Directed table: cold miss, then PLRU eviction order in set 0
    for (int i = 0; i < 11; i++) begin
      read_op(tbl[i].addr, tbl[i].k, $sformatf("tbl%0d", i), h);
      chk($sformatf("tbl%0d_hit", i), 32'(h), 32'(tbl[i].exp_hit));
      if (i == 0) begin
        chk("cold_hit_cnt", hit_cnt, 32'd1);
        chk("cold_miss_cnt", miss_cnt, 32'd1);
      end
    end
    chk("tbl_hit_cnt", hit_cnt, 32'(m_hits));
    chk("tbl_miss_cnt", miss_cnt, 32'(m_misses));

    // Flush in IDLE wins over a read that would hit
    proc_read = 1'b1; proc_addr = 30'h000; flush = 1'b1;
    #1 chk("flush_idle_stall", 32'(proc_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; proc_read = 1'b0;
    model_flush();
    read_op(30'h000, 0, "after_flush", h);
    chk("after_flush_hit", 32'(h), 32'd0);

    // Flush during FETCH: fill completes, next idle cycle invalidates
    proc_read = 1'b1; proc_addr = 30'h100;
    void'(model_access(30'h100));
    #1 chk("ff_miss_stall", 32'(proc_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("ff_fetch_mem_read", 32'(mem_read), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b1;
    #1 chk("ff_ready_stall", 32'(proc_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("ff_pending_stall", 32'(proc_stall), 32'd1);
    chk("ff_idle_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk);
    @(negedge clk);
    proc_read = 1'b0;
    model_flush();
    read_op(30'h100, 1, "ff_refetch", h);
    chk("ff_refetch_hit", 32'(h), 32'd0);
    read_op(30'h000, 0, "ff_zero", h);
    chk("ff_zero_hit", 32'(h), 32'd0);
    chk("flush_hit_cnt", hit_cnt, 32'(m_hits));
    chk("flush_miss_cnt", miss_cnt, 32'(m_misses));

    // Random reads over a few tags per set, with occasional flushes
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        proc_read = 1'($urandom_range(0, 1));
        proc_addr = 30'($urandom);
        #1 chk("rnd_flush_stall", 32'(proc_stall), 32'(proc_read));
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; proc_read = 1'b0;
        model_flush();
      end else begin
        read_op({22'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'd0} >> 3
                | 30'($urandom_range(0, 3)) | (30'($urandom_range(0, 7)) << 2)
                  | (30'($urandom_range(0, 5)) << 5) & 30'h00E0,
                int'($urandom_range(0, 3)), "rnd", h);
      end
    end
    chk("rnd_hit_cnt", hit_cnt, 32'(m_hits));
    chk("rnd_miss_cnt", miss_cnt, 32'(m_misses));

    // Reset in the middle of a fill
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    proc_read = 1'b1; proc_addr = 30'h200;
    #1 chk("rst_fill_stall", 32'(proc_stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1 chk("rst_fill_mem_read", 32'(mem_read), 32'd1);
    proc_read = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_hit_cnt", hit_cnt, 32'd0);
    chk("rst_mid_miss_cnt", miss_cnt, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("stray_ready_mem_read", 32'(mem_read), 32'd0);
    model_flush();
    m_hits = 0; m_misses = 0;
    read_op(30'h200, 0, "post_rst", h);
    chk("post_rst_hit", 32'(h), 32'd0);

    // Hit counter wraps to zero
    force dut.hit_cnt = 32'hFFFF_FFFF;
    #1 release dut.hit_cnt;
    #1 chk("wrap_preload", hit_cnt, 32'hFFFF_FFFF);
    read_op(30'h201, 0, "wrap", h);
    chk("wrap_hit", 32'(h), 32'd1);
    chk("wrap_hit_cnt", hit_cnt, 32'd0);

    // Direct-mapped build: conflicting blocks always miss
    read1(30'h000, 1'b0);
    read1(30'h020, 1'b0);
    read1(30'h000, 1'b0);
    read1(30'h020, 1'b0);
    read1(30'h021, 1'b1);
    read1(30'h001, 1'b0);
    chk("w1_miss_cnt", x1_cnt, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
